// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, funct
// codes, FSM states, datapath mux selects and the decoded control bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] PC_PLUS4   = 2'b00;
  localparam logic [1:0] PC_BRANCH  = 2'b01;
  localparam logic [1:0] PC_JUMP    = 2'b10;
  localparam logic [1:0] PC_RS      = 2'b11;

  localparam logic       SRCA_PC    = 1'b0;
  localparam logic       SRCA_RS    = 1'b1;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_SIMM  = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  localparam logic [1:0] DST_RT     = 2'b00;
  localparam logic [1:0] DST_RD     = 2'b01;
  localparam logic [1:0] DST_RA     = 2'b10;

  localparam logic [1:0] M2R_ALU    = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // Memory wait counter width; covers MEM_TIMEOUT up to 255.
  localparam int CNT_W = 8;

  // Combinational control bundle decoded from state and inputs.
  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] mem2reg;
    logic       reg_write;
    logic       illegal;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control/handshake bundle between the multi-cycle control FSM (master)
// and the datapath/memory side (slave).
interface mc_control_fsm_if #(
  parameter int NB_OP    = 6,
  parameter int NB_FUNCT = 6
);
  logic                i_en;
  logic [NB_OP-1:0]    i_opcode;
  logic [NB_FUNCT-1:0] i_funct;
  logic                i_zero;
  logic                i_mem_ready;

  logic                o_mem_req;
  logic                o_mem_read;
  logic                o_mem_write;
  logic                o_iord;
  logic                o_ir_write;
  logic                o_pc_write;
  logic [1:0]          o_pc_src;
  logic                o_alu_src_a;
  logic [1:0]          o_alu_src_b;
  logic [1:0]          o_alu_op;
  logic [1:0]          o_reg_dst;
  logic [1:0]          o_mem2reg;
  logic                o_reg_write;
  logic                o_illegal;
  logic                o_halted;
  logic                o_err;
  logic [2:0]          o_state;

  modport master (
    input  i_en, i_opcode, i_funct, i_zero, i_mem_ready,
    output o_mem_req, o_mem_read, o_mem_write, o_iord, o_ir_write,
           o_pc_write, o_pc_src, o_alu_src_a, o_alu_src_b, o_alu_op,
           o_reg_dst, o_mem2reg, o_reg_write, o_illegal, o_halted,
           o_err, o_state
  );

  modport slave (
    output i_en, i_opcode, i_funct, i_zero, i_mem_ready,
    input  o_mem_req, o_mem_read, o_mem_write, o_iord, o_ir_write,
           o_pc_write, o_pc_src, o_alu_src_a, o_alu_src_b, o_alu_op,
           o_reg_dst, o_mem2reg, o_reg_write, o_illegal, o_halted,
           o_err, o_state
  );
endinterface

// File: rtl/mc_main_decoder.sv
// Combinational opcode classifier. JR is split out of the R-type class so
// the FSM never runs it through EXEC; with EN_JAL=0 both JAL and JR fall
// into the illegal class.
module mc_main_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int NB_OP    = 6,
  parameter int NB_FUNCT = 6,
  parameter int EN_JAL   = 1
) (
  input  logic [NB_OP-1:0]    opcode,
  input  logic [NB_FUNCT-1:0] funct,
  output logic                is_r,
  output logic                is_lw,
  output logic                is_sw,
  output logic                is_beq,
  output logic                is_bne,
  output logic                is_addi,
  output logic                is_j,
  output logic                is_jal,
  output logic                is_jr,
  output logic                is_halt,
  output logic                is_illegal
);
  localparam logic JAL_ON = (EN_JAL != 0);

  logic r_fmt;
  logic fn_jr;

  assign r_fmt      = (opcode == NB_OP'(OP_RTYPE));
  assign fn_jr      = (funct == NB_FUNCT'(FN_JR));

  assign is_r       = r_fmt & ~fn_jr;
  assign is_jr      = r_fmt & fn_jr & JAL_ON;
  assign is_lw      = (opcode == NB_OP'(OP_LW));
  assign is_sw      = (opcode == NB_OP'(OP_SW));
  assign is_beq     = (opcode == NB_OP'(OP_BEQ));
  assign is_bne     = (opcode == NB_OP'(OP_BNE));
  assign is_addi    = (opcode == NB_OP'(OP_ADDI));
  assign is_j       = (opcode == NB_OP'(OP_J));
  assign is_jal     = (opcode == NB_OP'(OP_JAL)) & JAL_ON;
  assign is_halt    = (opcode == NB_OP'(OP_HALT));

  assign is_illegal = ~(is_r | is_jr | is_lw | is_sw | is_beq | is_bne |
                        is_addi | is_j | is_jal | is_halt);
endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with a
// bounded memory wait. Only state, the wait counter and the sticky error
// flag are registered; every other output is decoded from them and the
// current inputs, and is forced to zero while reset is held.
module mc_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int NB_OP       = 6,
  parameter int NB_FUNCT    = 6,
  parameter int MEM_TIMEOUT = 16,
  parameter int EN_JAL      = 1
) (
  input  logic           clk,
  input  logic           i_rst,
  mc_control_fsm_if.master bus
);
  // Counter value on the last permitted wait cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             err;
  logic             timeout;
  ctrl_t            ctl;

  logic is_r, is_lw, is_sw, is_beq, is_bne, is_addi;
  logic is_j, is_jal, is_jr, is_halt, is_illegal;

  mc_main_decoder #(
    .NB_OP    (NB_OP),
    .NB_FUNCT (NB_FUNCT),
    .EN_JAL   (EN_JAL)
  ) u_dec (
    .opcode     (bus.i_opcode),
    .funct      (bus.i_funct),
    .is_r       (is_r),
    .is_lw      (is_lw),
    .is_sw      (is_sw),
    .is_beq     (is_beq),
    .is_bne     (is_bne),
    .is_addi    (is_addi),
    .is_j       (is_j),
    .is_jal     (is_jal),
    .is_jr      (is_jr),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  // Next-state and control decode from current state, IR fields and handshakes.
  always_comb begin
    ctl     = '0;
    nxt     = state;
    timeout = 1'b0;
    case (state)
      ST_FETCH: begin
        if (bus.i_en) begin
          ctl.mem_req   = 1'b1;
          ctl.mem_read  = 1'b1;
          ctl.alu_src_a = SRCA_PC;
          ctl.alu_src_b = SRCB_FOUR;
          ctl.alu_op    = ALU_ADD;
          if (bus.i_mem_ready) begin
            ctl.ir_write = 1'b1;
            ctl.pc_write = 1'b1;
            ctl.pc_src   = PC_PLUS4;
            nxt          = ST_DECODE;
          end else if (wait_cnt == CNT_LAST) begin
            timeout = 1'b1;
            nxt     = ST_HALT;
          end
        end
      end
      ST_DECODE: begin
        ctl.alu_src_a = SRCA_PC;
        ctl.alu_src_b = SRCB_SHIMM;
        ctl.alu_op    = ALU_ADD;
        if (is_r | is_addi | is_lw | is_sw | is_beq | is_bne) begin
          nxt = ST_EXEC;
        end else if (is_j) begin
          ctl.pc_write = 1'b1;
          ctl.pc_src   = PC_JUMP;
          nxt          = ST_FETCH;
        end else if (is_jal) begin
          nxt = ST_WB;
        end else if (is_jr) begin
          ctl.pc_write = 1'b1;
          ctl.pc_src   = PC_RS;
          nxt          = ST_FETCH;
        end else if (is_halt) begin
          nxt = ST_HALT;
        end else begin
          ctl.illegal = 1'b1;
          nxt         = ST_FETCH;
        end
      end
      ST_EXEC: begin
        ctl.alu_src_a = SRCA_RS;
        nxt           = ST_FETCH;
        if (is_r) begin
          ctl.alu_op    = ALU_FUNCT;
          ctl.alu_src_b = SRCB_RT;
          nxt           = ST_WB;
        end else if (is_addi | is_lw | is_sw) begin
          ctl.alu_op    = ALU_ADD;
          ctl.alu_src_b = SRCB_SIMM;
          nxt           = is_addi ? ST_WB : ST_MEM;
        end else if (is_beq | is_bne) begin
          ctl.alu_op    = ALU_SUB;
          ctl.alu_src_b = SRCB_RT;
          ctl.pc_write  = ~(bus.i_zero ^ is_beq);
          ctl.pc_src    = PC_BRANCH;
        end
      end
      ST_MEM: begin
        ctl.mem_req   = 1'b1;
        ctl.iord      = 1'b1;
        ctl.mem_read  = is_lw;
        ctl.mem_write = is_sw;
        if (bus.i_mem_ready) begin
          nxt = is_lw ? ST_WB : ST_FETCH;
        end else if (wait_cnt == CNT_LAST) begin
          timeout = 1'b1;
          nxt     = ST_HALT;
        end
      end
      ST_WB: begin
        ctl.reg_write = 1'b1;
        nxt           = ST_FETCH;
        if (is_r) begin
          ctl.reg_dst = DST_RD;
          ctl.mem2reg = M2R_ALU;
        end else if (is_lw) begin
          ctl.reg_dst = DST_RT;
          ctl.mem2reg = M2R_MDR;
        end else if (is_jal) begin
          ctl.reg_dst  = DST_RA;
          ctl.mem2reg  = M2R_PC;
          ctl.pc_write = 1'b1;
          ctl.pc_src   = PC_JUMP;
        end else begin
          ctl.reg_dst = DST_RT;
          ctl.mem2reg = M2R_ALU;
        end
      end
      ST_HALT: begin
        ctl.halted = 1'b1;
      end
      default: begin
        nxt = ST_FETCH;
      end
    endcase
    // Reset aborts any access in the same cycle: no request, no strobe.
    if (i_rst) begin
      ctl = '0;
    end
  end

  // State, memory wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state    <= ST_FETCH;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state <= nxt;
      if (timeout) begin
        err <= 1'b1;
      end
      if ((nxt != state) && ((nxt == ST_FETCH) || (nxt == ST_MEM))) begin
        wait_cnt <= '0;
      end else if (ctl.mem_req && !bus.i_mem_ready) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.o_mem_req   = ctl.mem_req;
  assign bus.o_mem_read  = ctl.mem_read;
  assign bus.o_mem_write = ctl.mem_write;
  assign bus.o_iord      = ctl.iord;
  assign bus.o_ir_write  = ctl.ir_write;
  assign bus.o_pc_write  = ctl.pc_write;
  assign bus.o_pc_src    = ctl.pc_src;
  assign bus.o_alu_src_a = ctl.alu_src_a;
  assign bus.o_alu_src_b = ctl.alu_src_b;
  assign bus.o_alu_op    = ctl.alu_op;
  assign bus.o_reg_dst   = ctl.reg_dst;
  assign bus.o_mem2reg   = ctl.mem2reg;
  assign bus.o_reg_write = ctl.reg_write;
  assign bus.o_illegal   = ctl.illegal;
  assign bus.o_halted    = ctl.halted;
  assign bus.o_err       = err & ~i_rst;
  assign bus.o_state     = i_rst ? ST_FETCH : state;
endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have parameter NB_OP, default 6, opcode width.
REQ-002 SHALL have parameter NB_FUNCT, default 6, funct width.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 16, maximum wait cycles per memory access (range 1..255).
REQ-004 SHALL have parameter EN_JAL, default 1; when 1, JAL and JR are decoded; when 0, they are treated as illegal.
REQ-005 SHALL use a single clock and a synchronous, active-high reset.
REQ-006 Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- i_rst, in, 1: synchronous active-high reset.
- i_en, in, 1: run enable, sampled only in FETCH (single-step support).
- i_opcode, in, NB_OP: instruction [31:26] from the IR.
- i_funct, in, NB_FUNCT: instruction [5:0].
- i_zero, in, 1: ALU zero flag.
- i_mem_ready, in, 1: memory access complete.
- o_mem_req, out, 1: memory request.
- o_mem_read, out, 1: memory read.
- o_mem_write, out, 1: memory write.
- o_iord, out, 1: address source (0 = PC, 1 = ALUOut).
- o_ir_write, out, 1: IR load strobe.
- o_pc_write, out, 1: PC load strobe.
- o_pc_src, out, 2: PC source (00 = PC+4, 01 = branch target, 10 = jump target, 11 = register rs).
- o_alu_src_a, out, 1: ALU A source (0 = PC, 1 = rs).
- o_alu_src_b, out, 2: ALU B source (00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate).
- o_alu_op, out, 2: ALU op (00 = add, 01 = sub, 10 = funct).
- o_reg_dst, out, 2: destination register (00 = rt, 01 = rd, 10 = $31).
- o_mem2reg, out, 2: write-back source (00 = ALUOut, 01 = MDR, 10 = PC).
- o_reg_write, out, 1: register-file write strobe.
- o_illegal, out, 1: one-cycle pulse on an illegal opcode.
- o_halted, out, 1: FSM is in HALT.
- o_err, out, 1: sticky memory-timeout flag.
- o_state, out, 3: current state, for debug.

Function
REQ-007 SHALL implement the states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-008 In FETCH, if i_en=0, SHALL hold state with o_mem_req=0 and all strobes 0.
REQ-009 In FETCH with i_en=1, SHALL assert o_mem_req, o_mem_read and o_iord=0. On i_mem_ready, in the same cycle, SHALL assert o_ir_write and o_pc_write with o_pc_src=00, and go to DECODE.
REQ-010 DECODE SHALL last 1 cycle and drive o_alu_src_a=0, o_alu_src_b=11, o_alu_op=00 (branch-target precompute).
REQ-011 DECODE SHALL route each instruction as follows:
- R, ADDI, LW, SW, BEQ, BNE: go to EXEC.
- J: o_pc_write=1, o_pc_src=10, go to FETCH.
- JAL: go to WB.
- JR (R-type with funct 001000): o_pc_write=1, o_pc_src=11, go to FETCH.
- HALT (111111): go to HALT.
- Any other opcode: o_illegal pulse, go to FETCH.
REQ-012 EXEC SHALL route each instruction as follows:
- R: alu_op=10, src_b=00, go to WB.
- ADDI, LW, SW: alu_op=00, src_b=10. ADDI goes to WB; LW and SW go to MEM.
- BEQ/BNE: alu_op=01; o_pc_write=(i_zero XNOR is_beq), o_pc_src=01; go to FETCH.
REQ-013 In MEM, SHALL assert o_mem_req and o_iord=1, plus o_mem_read for LW or o_mem_write for SW. On i_mem_ready, LW goes to WB and SW goes to FETCH.
REQ-014 WB SHALL assert o_reg_write for exactly 1 cycle, then go to FETCH. Selects per instruction:
- R: dst=01, m2r=00.
- ADDI: dst=00, m2r=00.
- LW: dst=00, m2r=01.
- JAL: dst=10, m2r=10, plus o_pc_write=1 and o_pc_src=10.
REQ-015 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle o_mem_req=1 without i_mem_ready. When it reaches MEM_TIMEOUT, the FSM SHALL set o_err, drop o_mem_req and go to HALT.
REQ-016 i_mem_ready arriving in the same cycle the counter reaches MEM_TIMEOUT SHALL count as success (no error).
REQ-017 i_mem_ready SHALL be ignored when o_mem_req=0.
REQ-018 HALT SHALL be terminal until i_rst, with o_halted=1 and all strobes 0.
REQ-019 Cycle counts SHALL be, with zero-wait memory:
- R/ADDI: 4.
- LW: 5.
- SW: 4.
- Branch: 3.
- J/JR: 2.
- JAL: 3.
REQ-020 i_en falling mid-instruction SHALL NOT stall; the instruction SHALL complete.

Reset
REQ-021 While i_rst=1, state SHALL be FETCH, the counter 0, o_err=0, and all outputs 0, including o_mem_req.
REQ-022 Reset asserted mid-access SHALL abort the access immediately, with no strobe in that cycle.

Structure
REQ-023 Opcode/funct codes, state encodings, pc_src/alu_src/reg_dst/mem2reg/alu_op encodings SHALL live in the shared package mips_ctrl_pkg.
REQ-024 The combinational opcode classification SHALL be the sub-module mc_main_decoder. It outputs is_r, is_lw, is_sw, is_beq, is_bne, is_addi, is_j, is_jal, is_jr, is_halt and is_illegal.
REQ-025 State, counter and o_err SHALL be the only registers; all other outputs SHALL be decoded from state and inputs.

Verification
REQ-026 Bench SHALL cover the following directed scenarios:
- LW, memory ready after 2 cycles on both accesses: states F(3) D E M(3) W; o_reg_write for 1 cycle with dst=00, m2r=01.
- BEQ with i_zero=1, then BNE with i_zero=1: first instruction o_pc_write=1 with pc_src=01 in EXEC; second instruction o_pc_write=0.
- MEM_TIMEOUT=4, SW with i_mem_ready never asserted: o_err=1 and o_halted=1 after 4 MEM cycles; o_mem_write drops.
- Opcode 010101: o_illegal pulses 1 cycle in DECODE, then FETCH; with EN_JAL=0, JAL also pulses o_illegal.
- i_en=0 for 5 cycles in FETCH: no o_mem_req; with i_en=1, fetch proceeds; i_rst during MEM: next state FETCH with all outputs 0.
